pixel_unstacker: RTL and testbench

PIXEL_UNSTACKER -- requirements
Module: pixel_unstacker

---
 rtl/pixel_unstacker_if.sv | 32 +++
 rtl/pixel_unstacker.sv | 70 +++++++
 tb/tb_pixel_unstacker.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pixel_unstacker_if.sv
// Chunk-in / pixel-out handshake bundle for pixel_unstacker.
// The master side feeds DRAM read chunks and consumes pixels; the slave is the unstacker.
interface pixel_unstacker_if #(
  parameter int HRES = 1280,
  parameter int VRES = 720
);
  localparam int PIX_AW   = $clog2(HRES * VRES);
  localparam int CHUNK_AW = $clog2(HRES * VRES / 8);

  logic                   chunk_valid_in;
  logic                   chunk_ready_out;
  logic [CHUNK_AW-1:0]    chunk_addr_in;
  logic [7:0][15:0]       chunk_data_in;
  logic                   pixel_valid_out;
  logic                   pixel_ready_in;
  logic [15:0]            pixel_out;
  logic [PIX_AW-1:0]      addr_out;
  logic                   frame_end_out;
  logic                   seq_error_out;

  modport master (
    output chunk_valid_in, chunk_addr_in, chunk_data_in, pixel_ready_in,
    input  chunk_ready_out, pixel_valid_out, pixel_out, addr_out,
           frame_end_out, seq_error_out
  );

  modport slave (
    input  chunk_valid_in, chunk_addr_in, chunk_data_in, pixel_ready_in,
    output chunk_ready_out, pixel_valid_out, pixel_out, addr_out,
           frame_end_out, seq_error_out
  );
endinterface

// File: rtl/pixel_unstacker.sv
// Unpacks 8-pixel DRAM read chunks into a one-pixel-per-cycle RGB565 stream,
// tracking linear chunk order and flagging any out-of-sequence chunk.
module pixel_unstacker #(
  parameter int HRES = 1280,
  parameter int VRES = 720
) (
  input  logic               clk_in,
  input  logic               rst_in,
  pixel_unstacker_if.slave   bus
);
  localparam int PIXELS   = HRES * VRES;
  localparam int CHUNKS   = PIXELS / 8;
  localparam int PIX_AW   = $clog2(PIXELS);
  localparam int CHUNK_AW = $clog2(CHUNKS);

  logic [7:0][15:0]    chunk_buf;
  logic [CHUNK_AW-1:0] buf_addr;
  logic [CHUNK_AW-1:0] expected_chunk;
  logic                full;
  logic [2:0]          index;
  logic                seq_error;
  logic                chunk_ready;
  logic                chunk_fire;
  logic                pixel_fire;
  logic [PIX_AW-1:0]   pix_addr;

  // A new chunk may land either into an empty buffer or on the very edge
  // the last buffered pixel leaves, which gives zero-bubble streaming.
  assign chunk_ready = !full || (index == 3'd7 && bus.pixel_ready_in);
  assign chunk_fire  = bus.chunk_valid_in && chunk_ready;
  assign pixel_fire  = full && bus.pixel_ready_in;
  assign pix_addr    = {buf_addr, index};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      chunk_buf      <= '0;
      buf_addr       <= '0;
      expected_chunk <= '0;
      full           <= 1'b0;
      index          <= 3'd0;
      seq_error      <= 1'b0;
    end else if (chunk_fire) begin
      chunk_buf <= bus.chunk_data_in;
      buf_addr  <= bus.chunk_addr_in;
      full      <= 1'b1;
      index     <= 3'd0;
      if (bus.chunk_addr_in != expected_chunk)
        seq_error <= 1'b1;
      // Resynchronise on whatever arrived so a single glitch flags once.
      if (bus.chunk_addr_in == CHUNK_AW'(CHUNKS - 1))
        expected_chunk <= '0;
      else
        expected_chunk <= bus.chunk_addr_in + CHUNK_AW'(1);
    end else if (pixel_fire) begin
      if (index == 3'd7) begin
        full  <= 1'b0;
        index <= 3'd0;
      end else begin
        index <= index + 3'd1;
      end
    end
  end

  assign bus.chunk_ready_out = chunk_ready;
  assign bus.pixel_valid_out = full;
  assign bus.pixel_out       = chunk_buf[index];
  assign bus.addr_out        = pix_addr;
  assign bus.frame_end_out   = full && (pix_addr == PIX_AW'(PIXELS - 1));
  assign bus.seq_error_out   = seq_error;
endmodule

// File: tb/tb_pixel_unstacker.sv
// Directed bench for pixel_unstacker on a small 16x4 frame so frame wrap is reachable;
// a scoreboard queue holds expected pixels, popped on each pixel handshake.
module tb_pixel_unstacker;
  localparam int HRES   = 16;
  localparam int VRES   = 4;
  localparam int PIXELS = HRES * VRES;

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] pix;
  } exp_t;

  logic clk_in;
  logic rst_in;
  pixel_unstacker_if #(.HRES(HRES), .VRES(VRES)) bus ();

  pixel_unstacker #(.HRES(HRES), .VRES(VRES)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  exp_t exp_q[$];
  int   assertions = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   pop_count  = 0;
  int   first_pop  = 0;
  int   last_pop   = 0;
  int   frame_ends = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] pix_val(input int addr, input int i, input int salt);
    return 16'(addr * 8 + i + salt * 'h1000);
  endfunction

  // Scoreboard side: every presented pixel is compared with the queue head.
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in && bus.pixel_valid_out) begin
      if (exp_q.size() == 0) begin
        assertions++;
        failures++;
        $error("[TB] FAIL unexpected_pixel observed addr=%0h expected none", bus.addr_out);
      end else begin
        e = exp_q[0];
        check_output("pixel", 32'(bus.pixel_out), 32'(e.pix));
        check_output("addr", 32'(bus.addr_out), 32'(e.addr));
        check_output("frame_end", 32'(bus.frame_end_out), 32'(e.addr == 6'(PIXELS - 1)));
        check_output("chunk_ready", 32'(bus.chunk_ready_out),
                     32'(e.addr[2:0] == 3'd7 && bus.pixel_ready_in));
        if (bus.pixel_ready_in) begin
          void'(exp_q.pop_front());
          if (pop_count == 0) first_pop = cyc;
          last_pop = cyc;
          pop_count++;
          if (bus.frame_end_out) frame_ends++;
        end
      end
    end
  end

  task automatic do_reset();
    rst_in = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
  endtask

  task automatic send_chunk(input int addr, input int salt);
    bit accepted = 1'b0;
    bus.chunk_valid_in = 1'b1;
    bus.chunk_addr_in  = 3'(addr);
    for (int i = 0; i < 8; i++) bus.chunk_data_in[i] = pix_val(addr, i, salt);
    for (int n = 0; n < 100 && !accepted; n++) begin
      @(negedge clk_in);
      accepted = bus.chunk_ready_out;
    end
    @(posedge clk_in);
    #1;
    if (!accepted) begin
      assertions++;
      failures++;
      $error("[TB] FAIL chunk_accept_timeout observed=0 expected=1 chunk=%0d", addr);
    end else begin
      for (int i = 0; i < 8; i++) exp_q.push_back('{addr: 6'(addr * 8 + i), pix: pix_val(addr, i, salt)});
    end
    bus.chunk_valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200; n++) begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() == 0 && !bus.pixel_valid_out) break;
    end
    check_output("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_index(input int idx);
    for (int n = 0; n < 50; n++) begin
      @(posedge clk_in);
      #1;
      if (bus.pixel_valid_out && bus.addr_out[2:0] == 3'(idx)) break;
    end
    check_output("reach_index", 32'(bus.addr_out[2:0]), 32'(idx));
  endtask

  initial begin
    bus.chunk_valid_in = 1'b0;
    bus.chunk_addr_in  = '0;
    bus.chunk_data_in  = '0;
    bus.pixel_ready_in = 1'b1;
    do_reset();

    check_output("rst_valid", 32'(bus.pixel_valid_out), 32'd0);
    check_output("rst_pixel", 32'(bus.pixel_out), 32'd0);
    check_output("rst_addr", 32'(bus.addr_out), 32'd0);
    check_output("rst_frame_end", 32'(bus.frame_end_out), 32'd0);
    check_output("rst_chunk_ready", 32'(bus.chunk_ready_out), 32'd1);
    check_output("rst_seq_error", 32'(bus.seq_error_out), 32'd0);

    // Single chunk 0 with element i = i, first pixel valid right after accept.
    send_chunk(0, 0);
    check_output("first_latency_valid", 32'(bus.pixel_valid_out), 32'd1);
    check_output("first_latency_addr", 32'(bus.addr_out), 32'd0);
    wait_drain();
    check_output("single_seq_error", 32'(bus.seq_error_out), 32'd0);

    // Back-to-back chunks 0,1,2: 24 pixels on 24 consecutive cycles.
    do_reset();
    pop_count = 0;
    send_chunk(0, 0);
    send_chunk(1, 0);
    send_chunk(2, 0);
    wait_drain();
    check_output("stream_count", 32'(pop_count), 32'd24);
    check_output("stream_span", 32'(last_pop - first_pop), 32'd23);

    // Stall five cycles at index 3; chunk valid held to prove it is not taken.
    send_chunk(3, 0);
    wait_index(3);
    bus.pixel_ready_in = 1'b0;
    bus.chunk_valid_in = 1'b1;
    bus.chunk_addr_in  = 3'd4;
    bus.chunk_data_in  = '1;
    repeat (5) begin
      @(negedge clk_in);
      check_output("stall_chunk_ready", 32'(bus.chunk_ready_out), 32'd0);
      check_output("stall_pixel", 32'(bus.pixel_out), 32'(pix_val(3, 3, 0)));
      check_output("stall_addr", 32'(bus.addr_out), 32'd27);
    end
    @(posedge clk_in);
    #1;
    bus.chunk_valid_in = 1'b0;
    bus.pixel_ready_in = 1'b1;
    wait_drain();
    check_output("stall_seq_error", 32'(bus.seq_error_out), 32'd0);

    // Out-of-order chunk 5 after 0 sets the sticky error; 6 resynchronises.
    do_reset();
    send_chunk(0, 0);
    check_output("order_seq_before", 32'(bus.seq_error_out), 32'd0);
    send_chunk(5, 0);
    check_output("order_seq_set", 32'(bus.seq_error_out), 32'd1);
    send_chunk(6, 0);
    check_output("order_seq_sticky", 32'(bus.seq_error_out), 32'd1);

    // Asynchronous reset mid-chunk discards the rest and clears the error.
    send_chunk(7, 1);
    wait_index(4);
    #2 rst_in = 1'b1;
    exp_q.delete();
    #1;
    check_output("arst_valid", 32'(bus.pixel_valid_out), 32'd0);
    check_output("arst_pixel", 32'(bus.pixel_out), 32'd0);
    check_output("arst_addr", 32'(bus.addr_out), 32'd0);
    check_output("arst_chunk_ready", 32'(bus.chunk_ready_out), 32'd1);
    check_output("arst_seq_error", 32'(bus.seq_error_out), 32'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    send_chunk(0, 2);
    check_output("arst_restart_addr", 32'(bus.addr_out), 32'd0);
    wait_drain();
    check_output("arst_seq_after", 32'(bus.seq_error_out), 32'd0);

    // Full frame then wrap to chunk 0: frame_end exactly once, no error.
    do_reset();
    frame_ends = 0;
    for (int c = 0; c < PIXELS / 8; c++) send_chunk(c, 0);
    send_chunk(0, 3);
    wait_drain();
    check_output("wrap_frame_ends", 32'(frame_ends), 32'd1);
    check_output("wrap_seq_error", 32'(bus.seq_error_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
